// File: rtl/mem_arb_pkg.sv
// Shared types for the SPI refill arbiter: FSM states, grant owner encoding
// and the default flash address width.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 20;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    RELEASE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/refill_timeout_ctr.sv
// Cycle counter bounding how long the arbiter waits for the SPI controller;
// expired flags the last permitted WAIT cycle.
module refill_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/spi_refill_arbiter.sv
// Arbitrates icache/dcache refill misses onto the single SPI flash controller
// and steers the returned word back to the granted cache as a one-cycle fetch.
module spi_refill_arbiter #(
  parameter int unsigned ADDR_W         = mem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              CLK_CPU,
  input  logic              resetp,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_addr,
  output logic              spi_req,
  output logic [ADDR_W-1:0] spi_addr,
  input  logic              SPI_data_ready,
  input  logic [DATA_W-1:0] SPI_data,
  output logic              icache_fetch,
  output logic              dcache_fetch,
  output logic [DATA_W-1:0] fill_data,
  output logic [1:0]        owner,
  output logic              busy,
  output logic              err_timeout
);

  import mem_arb_pkg::*;

  state_t state;
  owner_t own;
  logic   last_d;   // 1: dcache was served last, so icache wins a tie
  logic   dropped;  // owner's miss went low at some point during WAIT
  logic   expired;
  logic   owner_miss;
  logic   grant_d;
  logic   grant_i;

  refill_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (CLK_CPU),
    .rst    (resetp),
    .clear  (state == ISSUE),
    .enable (state == WAIT),
    .expired(expired)
  );

  always_comb begin
    owner_miss = (own == OWN_I) ? icache_miss : dcache_miss;
    grant_d    = dcache_miss && (!icache_miss || !last_d);
    grant_i    = icache_miss && !grant_d;
  end

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      state        <= IDLE;
      own          <= OWN_NONE;
      last_d       <= 1'b0;
      dropped      <= 1'b0;
      spi_req      <= 1'b0;
      spi_addr     <= '0;
      icache_fetch <= 1'b0;
      dcache_fetch <= 1'b0;
      fill_data    <= '0;
      err_timeout  <= 1'b0;
    end else begin
      spi_req      <= 1'b0;
      icache_fetch <= 1'b0;
      dcache_fetch <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            own      <= OWN_D;
            spi_addr <= dcache_addr;
            spi_req  <= 1'b1;
            state    <= ISSUE;
          end else if (grant_i) begin
            own      <= OWN_I;
            spi_addr <= icache_addr;
            spi_req  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          dropped <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          dropped <= dropped | !owner_miss;
          // The strobe is launched on the WAIT->DONE edge so it is high in DONE;
          // the drop check therefore includes the ready cycle itself.
          if (SPI_data_ready) begin
            state <= DONE;
            if (!dropped && owner_miss) begin
              fill_data <= SPI_data;
              if (own == OWN_I) begin
                icache_fetch <= 1'b1;
              end else begin
                dcache_fetch <= 1'b1;
              end
            end
          end else if (expired) begin
            err_timeout <= 1'b1;
            state       <= RELEASE;
          end
        end
        DONE: begin
          last_d <= (own == OWN_D);
          state  <= RELEASE;
        end
        RELEASE: begin
          own   <= OWN_NONE;
          state <= IDLE;
        end
        default: begin
          own   <= OWN_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

  assign owner = own;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_spi_refill_arbiter.sv
// Directed self-checking bench for spi_refill_arbiter (TIMEOUT_CYCLES=16).
module tb_spi_refill_arbiter;

  logic        CLK_CPU = 1'b0;
  logic        resetp = 1'b0;
  logic        icache_miss = 1'b0;
  logic [19:0] icache_addr = '0;
  logic        dcache_miss = 1'b0;
  logic [19:0] dcache_addr = '0;
  logic        spi_req;
  logic [19:0] spi_addr;
  logic        SPI_data_ready = 1'b0;
  logic [31:0] SPI_data = '0;
  logic        icache_fetch;
  logic        dcache_fetch;
  logic [31:0] fill_data;
  logic [1:0]  owner;
  logic        busy;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  spi_refill_arbiter #(
    .ADDR_W(20),
    .DATA_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK_CPU       (CLK_CPU),
    .resetp        (resetp),
    .icache_miss   (icache_miss),
    .icache_addr   (icache_addr),
    .dcache_miss   (dcache_miss),
    .dcache_addr   (dcache_addr),
    .spi_req       (spi_req),
    .spi_addr      (spi_addr),
    .SPI_data_ready(SPI_data_ready),
    .SPI_data      (SPI_data),
    .icache_fetch  (icache_fetch),
    .dcache_fetch  (dcache_fetch),
    .fill_data     (fill_data),
    .owner         (owner),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  task automatic tick();
    @(posedge CLK_CPU);
    #1;
  endtask

  task automatic do_reset();
    resetp = 1'b1;
    tick();
    tick();
    resetp = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({spi_req, icache_fetch, dcache_fetch, busy, err_timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000",
               {spi_req, icache_fetch, dcache_fetch, busy, err_timeout});
    end
    checks++;
    if (spi_addr !== 20'h0 || fill_data !== 32'h0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_regs: got addr=%h fill=%h owner=%0d required 0/0/0",
               spi_addr, fill_data, owner);
    end
  endtask

  task automatic test_single_icache();
    icache_addr = 20'h00100;
    icache_miss = 1'b1;
    tick();  // cycle 1
    checks++;
    if (spi_req !== 1'b1 || spi_addr !== 20'h00100 || owner !== 2'd1) begin
      errors++;
      $display("FAIL single_issue: got req=%b addr=%h owner=%0d required 1/00100/1",
               spi_req, spi_addr, owner);
    end
    tick();  // cycle 2
    checks++;
    if (spi_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_req_pulse: got req=%b busy=%b required 0/1", spi_req, busy);
    end
    tick();
    tick();
    tick();  // cycle 5
    SPI_data_ready = 1'b1;
    SPI_data = 32'hDEADBEEF;
    tick();  // cycle 6
    SPI_data_ready = 1'b0;
    checks++;
    if (icache_fetch !== 1'b1 || dcache_fetch !== 1'b0 || fill_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_fetch: got i=%b d=%b fill=%h required 1/0/deadbeef",
               icache_fetch, dcache_fetch, fill_data);
    end
    icache_miss = 1'b0;
    tick();  // cycle 7 RELEASE
    checks++;
    if (icache_fetch !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_release: got fetch=%b busy=%b required 0/1", icache_fetch, busy);
    end
    tick();  // cycle 8 IDLE
    checks++;
    if (busy !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL single_idle: got busy=%b owner=%0d required 0/0", busy, owner);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    icache_addr = 20'h00200;
    dcache_addr = 20'hAF010;
    icache_miss = 1'b1;
    dcache_miss = 1'b1;
    tick();  // ISSUE for D
    checks++;
    if (owner !== 2'd2 || spi_addr !== 20'hAF010 || spi_req !== 1'b1) begin
      errors++;
      $display("FAIL rr_first_d: got owner=%0d addr=%h req=%b required 2/af010/1",
               owner, spi_addr, spi_req);
    end
    tick();  // WAIT
    SPI_data_ready = 1'b1;
    SPI_data = 32'h11111111;
    tick();  // DONE
    SPI_data_ready = 1'b0;
    checks++;
    if (dcache_fetch !== 1'b1 || icache_fetch !== 1'b0 || fill_data !== 32'h11111111) begin
      errors++;
      $display("FAIL rr_d_fetch: got d=%b i=%b fill=%h required 1/0/11111111",
               dcache_fetch, icache_fetch, fill_data);
    end
    dcache_miss = 1'b0;
    tick();  // RELEASE
    tick();  // IDLE, pending icache miss granted at this edge
    checks++;
    if (busy !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL rr_gap_idle: got busy=%b owner=%0d required 0/0", busy, owner);
    end
    tick();  // ISSUE for I
    checks++;
    if (owner !== 2'd1 || spi_addr !== 20'h00200 || spi_req !== 1'b1) begin
      errors++;
      $display("FAIL rr_then_i: got owner=%0d addr=%h req=%b required 1/00200/1",
               owner, spi_addr, spi_req);
    end
    tick();  // WAIT
    SPI_data_ready = 1'b1;
    SPI_data = 32'h22222222;
    tick();  // DONE
    SPI_data_ready = 1'b0;
    checks++;
    if (icache_fetch !== 1'b1 || dcache_fetch !== 1'b0 || fill_data !== 32'h22222222) begin
      errors++;
      $display("FAIL rr_i_fetch: got i=%b d=%b fill=%h required 1/0/22222222",
               icache_fetch, dcache_fetch, fill_data);
    end
    icache_miss = 1'b0;
    tick();  // RELEASE
    tick();  // IDLE
    icache_addr = 20'h00300;
    dcache_addr = 20'hAF030;
    icache_miss = 1'b1;
    dcache_miss = 1'b1;
    tick();  // ISSUE
    checks++;
    if (owner !== 2'd2 || spi_addr !== 20'hAF030) begin
      errors++;
      $display("FAIL rr_second_pair: got owner=%0d addr=%h required 2/af030", owner, spi_addr);
    end
    tick();  // WAIT
    SPI_data_ready = 1'b1;
    SPI_data = 32'h33333333;
    tick();  // DONE
    SPI_data_ready = 1'b0;
    icache_miss = 1'b0;
    dcache_miss = 1'b0;
    tick();
    tick();  // IDLE
  endtask

  task automatic test_addr_hold();
    dcache_addr = 20'hAF020;
    dcache_miss = 1'b1;
    tick();  // ISSUE
    dcache_addr = 20'h12345;
    tick();
    tick();  // WAIT
    checks++;
    if (spi_addr !== 20'hAF020) begin
      errors++;
      $display("FAIL addr_hold: got %h required af020", spi_addr);
    end
    SPI_data_ready = 1'b1;
    SPI_data = 32'hCAFEF00D;
    tick();  // DONE
    SPI_data_ready = 1'b0;
    checks++;
    if (dcache_fetch !== 1'b1 || icache_fetch !== 1'b0 || fill_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL addr_hold_fetch: got d=%b i=%b fill=%h required 1/0/cafef00d",
               dcache_fetch, icache_fetch, fill_data);
    end
    dcache_miss = 1'b0;
    tick();
    tick();  // IDLE
  endtask

  task automatic test_miss_drop();
    icache_addr = 20'h00400;
    icache_miss = 1'b1;
    tick();  // ISSUE
    tick();  // WAIT
    icache_miss = 1'b0;
    tick();  // WAIT
    SPI_data_ready = 1'b1;
    SPI_data = 32'h55555555;
    tick();  // DONE
    SPI_data_ready = 1'b0;
    checks++;
    if (icache_fetch !== 1'b0 || dcache_fetch !== 1'b0 || busy !== 1'b1 || owner !== 2'd1) begin
      errors++;
      $display("FAIL drop_done: got i=%b d=%b busy=%b owner=%0d required 0/0/1/1",
               icache_fetch, dcache_fetch, busy, owner);
    end
    checks++;
    if (fill_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL drop_discard: got fill=%h required cafef00d", fill_data);
    end
    tick();  // RELEASE
    checks++;
    if (icache_fetch !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_release: got fetch=%b busy=%b required 0/1", icache_fetch, busy);
    end
    tick();  // IDLE
    checks++;
    if (busy !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL drop_idle: got busy=%b owner=%0d required 0/0", busy, owner);
    end
  endtask

  task automatic test_timeout();
    int fetches;
    fetches = 0;
    icache_addr = 20'h00500;
    icache_miss = 1'b1;
    tick();  // cycle 1 ISSUE
    tick();  // cycle 2, first WAIT cycle
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got err=%b busy=%b required 0/1", err_timeout, busy);
    end
    for (int i = 0; i < 15; i++) begin
      tick();  // cycles 3..17, WAIT cycles 2..16
      if (icache_fetch || dcache_fetch) fetches++;
    end
    tick();  // cycle 18 RELEASE
    if (icache_fetch || dcache_fetch) fetches++;
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b1 || fetches !== 0) begin
      errors++;
      $display("FAIL timeout_flag: got err=%b busy=%b fetches=%0d required 1/1/0",
               err_timeout, busy, fetches);
    end
    tick();  // cycle 19 IDLE
    checks++;
    if (busy !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b owner=%0d required 0/0", busy, owner);
    end
    tick();  // cycle 20 re-grant
    checks++;
    if (owner !== 2'd1 || spi_req !== 1'b1 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_regrant: got owner=%0d req=%b err=%b required 1/1/1",
               owner, spi_req, err_timeout);
    end
    icache_miss = 1'b0;
    tick();  // WAIT
    SPI_data_ready = 1'b1;
    tick();  // DONE
    SPI_data_ready = 1'b0;
    tick();
    tick();  // IDLE
  endtask

  task automatic test_reset_in_wait();
    icache_addr = 20'h00600;
    icache_miss = 1'b1;
    tick();  // ISSUE
    tick();
    tick();  // WAIT
    resetp = 1'b1;
    tick();
    checks++;
    if ({spi_req, icache_fetch, dcache_fetch, busy, err_timeout} !== 5'b0 ||
        spi_addr !== 20'h0 || fill_data !== 32'h0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_wait: got flags=%b addr=%h fill=%h owner=%0d required 0/0/0/0",
               {spi_req, icache_fetch, dcache_fetch, busy, err_timeout}, spi_addr, fill_data, owner);
    end
    icache_miss = 1'b0;
    resetp = 1'b0;
    tick();
    SPI_data_ready = 1'b1;
    SPI_data = 32'h77777777;
    tick();
    SPI_data_ready = 1'b0;
    checks++;
    if (icache_fetch !== 1'b0 || dcache_fetch !== 1'b0 || busy !== 1'b0 || fill_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_late_ready: got i=%b d=%b busy=%b fill=%h required 0/0/0/0",
               icache_fetch, dcache_fetch, busy, fill_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_icache();
    test_round_robin();
    test_addr_hold();
    test_miss_drop();
    test_timeout();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_refill_arbiter.md
# spi_refill_arbiter

Shares the single SPI flash controller between the L1 instruction cache and the L1 data cache refill paths. Each cache raises a level-sensitive miss with a 20-bit byte address. The block grants one requester at a time and latches that requester's address. It issues a one-cycle request to the SPI controller, captures the returned word, and steers a one-cycle fetch pulse plus the data to the granted cache. It sits inside the memory subsystem, between the two caches and the SPI flash controller, and replaces the direct fan-out of SPI_data_ready to both caches.

## Interface
- ADDR_W, 20, flash address width (byte address, bits 19:0)
- DATA_W, 32, refill word width
- TIMEOUT_CYCLES, 4096, maximum WAIT cycles before a transaction is abandoned

Ports:
- CLK_CPU  in  1  CPU clock; all state updates on its rising edge
- resetp  in  1  reset, synchronous, active-high
- icache_miss  in  1  instruction cache refill request, held high until served
- icache_addr  in  ADDR_W  instruction refill address
- dcache_miss  in  1  data cache refill request, held high until served
- dcache_addr  in  ADDR_W  data refill address
- spi_req  out  1  one-cycle start pulse to the SPI controller
- spi_addr  out  ADDR_W  latched address of the granted requester
- SPI_data_ready  in  1  SPI controller word-valid pulse
- SPI_data  in  DATA_W  word returned by the SPI controller
- icache_fetch  out  1  one-cycle write strobe to the instruction cache
- dcache_fetch  out  1  one-cycle write strobe to the data cache
- fill_data  out  DATA_W  registered refill word, valid while a fetch strobe is high
- owner  out  2  current grant: 0 none, 1 icache, 2 dcache
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  sticky flag, set when a transaction times out

## Operation
- States: IDLE, ISSUE, WAIT, DONE, RELEASE.
- **IDLE:**
  - Only dcache_miss high: grant D.
  - Only icache_miss high: grant I.
  - Both high: grant the requester not served last (round-robin pointer). After reset the pointer favours D.
  - On any grant: latch the address into spi_addr, set owner, go to ISSUE.
- **ISSUE:** spi_req=1 for exactly this cycle, clear the timeout counter, go to WAIT.
- **WAIT:**
  - The counter increments every cycle.
  - SPI_data_ready=1: fill_data <= SPI_data, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ready: set err_timeout, go to RELEASE with no fetch pulse.
- **DONE:**
  - Pulse the owner's fetch strobe for one cycle and update the round-robin pointer to the owner.
  - Exception: if the owner's miss dropped at any point during WAIT (for example, a fetch redirect), suppress the strobe and discard the word.
  - Go to RELEASE.
- **RELEASE:** no grant this cycle, so the served cache can drop its miss. Clear owner, go to IDLE.
- Request-side inputs:
  - Address inputs are ignored after the grant; changes during a transaction do not affect spi_addr.
  - A miss from the non-owner is not lost. It stays pending and is arbitrated in the next IDLE.
- SPI-side input: SPI_data_ready outside WAIT is ignored.
- err_timeout clears only on reset.

## Timing
- Reset values: state IDLE, spi_req 0, spi_addr 0, icache_fetch 0, dcache_fetch 0, fill_data 0, owner 0, busy 0, err_timeout 0, pointer favouring D, counter 0.
- Reset asserted in any state: all of the above take effect at the next edge. An in-flight SPI transaction is abandoned, and a later SPI_data_ready is ignored because the block is not in WAIT.
- Cycle-level sequence:
  - Miss seen in IDLE at cycle 0.
  - spi_req high at cycle 1.
  - SPI_data_ready at cycle N ≥ 2.
  - Fetch strobe and fill_data at cycle N+1.
  - RELEASE at cycle N+2.
  - IDLE at cycle N+3; the earliest next grant is at N+3.
- Minimum arbiter overhead: 4 cycles per refill on top of SPI latency.
- Registered outputs: spi_req, spi_addr, fetch strobes, fill_data, owner and err_timeout are registered, with no combinational path from inputs.
- busy is decoded from the state register.

## Structure
- **Shared package mem_arb_pkg:**
  - state enum: IDLE, ISSUE, WAIT, DONE, RELEASE.
  - owner enum: OWN_NONE=0, OWN_I=1, OWN_D=2.
  - Default constant ADDR_W=20.
- **Sub-module refill_timeout_ctr:**
  - Parameterised width is $clog2(TIMEOUT_CYCLES).
  - Inputs: clear, enable. Output: expired.
- Everything else lives in one always_ff FSM plus output registers.

## Test plan
- Reset then icache_miss=1, icache_addr=0x00100, SPI_data_ready at cycle 5 with 0xDEADBEEF -> spi_req at cycle 1, spi_addr=0x00100, icache_fetch at cycle 6 with fill_data=0xDEADBEEF, dcache_fetch stays 0.
- Both misses raised together after reset (I=0x00200, D=0xAF010) -> D granted first. After D's fetch and RELEASE, I granted with spi_addr=0x00200. The next simultaneous pair is granted to D again, because the round-robin pointer is updated after each fetch and points to I.
- dcache_addr changed to 0x12345 during WAIT for a grant at 0xAF020 -> spi_addr holds 0xAF020, and fill_data is delivered to the dcache.
- icache_miss dropped during WAIT, then SPI_data_ready=1 -> no icache_fetch, state passes DONE -> RELEASE -> IDLE, owner returns to 0.
- TIMEOUT_CYCLES=16, no SPI_data_ready -> err_timeout=1 at WAIT cycle 16, no fetch strobe, IDLE two cycles later, re-grant if the miss is still high.
- resetp asserted in WAIT, then SPI_data_ready one cycle after release -> all outputs at reset values and no fetch strobe.
